// File: rtl/karatsuba_mac_pkg.sv
// Shared definitions for the Karatsuba multiply-accumulate stage: FSM encoding and
// the operand width the combinational multiplier is built for.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

    localparam int MUL_W = 16;

    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/karatsuba_mac_if.sv
// Operand stream in, accumulated-result stream out; both valid/ready.
// slave = the MAC block, master = the operand source / result sink.
interface karatsuba_mac_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/karatsuba_mac_mul.sv
// Combinational 16x16 unsigned multiplier, one level of Karatsuba on 8-bit halves.
// Zero latency; no flow control.
module mul_karatsuba (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [7:0]  ah, al, bh, bl;
    logic [8:0]  sa, sb;
    logic [15:0] z2, z0;
    logic [17:0] zm, z1;

    assign ah = a[15:8];
    assign al = a[7:0];
    assign bh = b[15:8];
    assign bl = b[7:0];

    assign sa = 9'(ah) + 9'(al);
    assign sb = 9'(bh) + 9'(bl);

    assign z2 = 16'(ah) * 16'(bh);
    assign z0 = 16'(al) * 16'(bl);
    assign zm = 18'(sa) * 18'(sb);

    // Cross term; never negative since (ah+al)(bh+bl) >= ah*bh + al*bl.
    assign z1 = zm - 18'(z2) - 18'(z0);

    assign p = {z2, z0} + (32'(z1) << 8);
endmodule

// File: rtl/karatsuba_mac.sv
// Registers operand beats into mul_karatsuba and sums products per burst; result valid
// two edges after the last accept, held until out_ready (in_ready low while draining/holding).
module karatsuba_mac
    import mac_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int BURST_LEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    karatsuba_mac_if.slave  bus
);
    localparam int CNT_W  = cnt_width(BURST_LEN);
    localparam int PROD_W = 2 * DATA_W;

    generate
        if (DATA_W != MUL_W) begin : g_bad_data_w
            $error("karatsuba_mac: DATA_W must be 16 to match mul_karatsuba");
        end
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("karatsuba_mac: ACC_W must be at least 2*DATA_W");
        end
        if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst
            $error("karatsuba_mac: BURST_LEN must be in 1..256");
        end
    endgenerate

    mac_state_t        state, state_nxt;
    logic              in_rdy, out_vld, release_res;
    logic              accept, last_beat;

    logic [DATA_W-1:0] op_a, op_b;
    logic              op_vld;
    logic [PROD_W-1:0] prod;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    sum;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    assign accept    = bus.in_valid & in_rdy;
    assign last_beat = bus.in_last | (cnt == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        release_res = 1'b0;
        case (state)
            ACCUM: begin
                in_rdy = 1'b1;
                if (bus.in_valid && last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    release_res = 1'b1;
                    state_nxt   = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_vld <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            op_vld <= accept;
            if (accept) begin
                op_a <= bus.in_a;
                op_b <= bus.in_b;
            end
        end
    end

    mul_karatsuba u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // One extra bit catches the carry that makes the overflow flag sticky.
    assign sum = {1'b0, acc} + (ACC_W + 1)'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (release_res) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else begin
            if (op_vld) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end
            if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_acc   = acc;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_karatsuba_mac.sv
// Directed bench for karatsuba_mac: a 40-bit instance for most steps and a 33-bit
// instance for the wrap/overflow step, plus random bursts against a running-sum model.
module tb_karatsuba_mac;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_a, in_b;

    karatsuba_mac_if #(.DATA_W(16), .ACC_W(40), .CNT_W(4)) m0 ();
    karatsuba_mac_if #(.DATA_W(16), .ACC_W(33), .CNT_W(4)) m1 ();

    karatsuba_mac #(.DATA_W(16), .ACC_W(40), .BURST_LEN(8)) u_dut0 (
        .clk (clk), .rst (rst), .bus (m0)
    );
    karatsuba_mac #(.DATA_W(16), .ACC_W(33), .BURST_LEN(8)) u_dut1 (
        .clk (clk), .rst (rst), .bus (m1)
    );

    assign m0.in_valid  = in_valid & ~sel;
    assign m1.in_valid  = in_valid & sel;
    assign m0.out_ready = out_ready & ~sel;
    assign m1.out_ready = out_ready & sel;
    assign m0.in_a = in_a;
    assign m1.in_a = in_a;
    assign m0.in_b = in_b;
    assign m1.in_b = in_b;
    assign m0.in_last = in_last;
    assign m1.in_last = in_last;

    logic        rdy, ovld, oovf;
    logic [39:0] oacc;
    logic [3:0]  ocnt;
    assign rdy  = sel ? m1.in_ready  : m0.in_ready;
    assign ovld = sel ? m1.out_valid : m0.out_valid;
    assign oacc = sel ? 40'(m1.out_acc) : m0.out_acc;
    assign ocnt = sel ? m1.out_count : m0.out_count;
    assign oovf = sel ? m1.out_ovf   : m0.out_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat after `gap` idle cycles (in_last toggled while idle) and hold until accepted.
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last, input int gap);
        int g = 0;
        repeat (gap) begin
            @(negedge clk);
            in_last = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!rdy && g < 64) begin
            @(negedge clk);
            g++;
        end
        chk("beat_timeout", 64'(g < 64), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(input int dly, output logic [39:0] r_acc, output logic [3:0] r_cnt,
                            output logic r_ovf);
        int g = 0;
        @(posedge clk);
        #1;
        while (!ovld && g < 64) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("result_timeout", 64'(g < 64), 64'd1);
        r_acc = oacc;
        r_cnt = ocnt;
        r_ovf = oovf;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] r_acc;
        logic [3:0]  r_cnt;
        logic        r_ovf;
        logic [40:0] m_sum;
        logic [39:0] m_acc;
        logic        m_ovf;
        logic [15:0] ra, rb;
        int          len;
        logic        rl;

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_a = '0; in_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ovld), 64'd0);
        chk("rst_out_acc",   64'(oacc), 64'd0);
        chk("rst_out_count", 64'(ocnt), 64'd0);
        chk("rst_out_ovf",   64'(oovf), 64'd0);
        chk("rst_in_ready",  64'(rdy),  64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Full burst of 8, result consumed immediately; in_ready low exactly 2 clks
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) beat(16'(i), 16'd2, 1'b0, 0);
        chk("full_rdy_drain", 64'(rdy), 64'd0);
        @(posedge clk);
        #1;
        chk("full_rdy_hold", 64'(rdy),  64'd0);
        chk("full_valid",    64'(ovld), 64'd1);
        chk("full_acc",      64'(oacc), 64'd72);
        chk("full_count",    64'(ocnt), 64'd8);
        chk("full_ovf",      64'(oovf), 64'd0);
        @(posedge clk);
        #1;
        chk("full_rdy_back", 64'(rdy),  64'd1);
        chk("full_valid_lo", 64'(ovld), 64'd0);
        out_ready = 1'b0;

        // Early last: 3 x 0xFFFF*0xFFFF
        beat(16'hFFFF, 16'hFFFF, 1'b0, 0);
        beat(16'hFFFF, 16'hFFFF, 1'b0, 0);
        beat(16'hFFFF, 16'hFFFF, 1'b1, 0);
        wait_res(0, r_acc, r_cnt, r_ovf);
        chk("early_acc",   64'(r_acc), 64'h2_FFFA_0003);
        chk("early_count", 64'(r_cnt), 64'd3);
        chk("early_ovf",   64'(r_ovf), 64'd0);

        // Backpressure: pending result with in_valid held high
        beat(16'd10, 16'd10, 1'b0, 0);
        beat(16'd20, 16'd1,  1'b1, 0);
        in_valid = 1'b1; in_a = 16'd7; in_b = 16'd9; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(ovld), 64'd1);
            chk("bp_acc",   64'(oacc), 64'd120);
            chk("bp_count", 64'(ocnt), 64'd2);
            chk("bp_rdy",   64'(rdy),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel_rdy",   64'(rdy),  64'd1);
        chk("bp_rel_valid", 64'(ovld), 64'd0);
        chk("bp_rel_acc",   64'(oacc), 64'd0);
        chk("bp_rel_count", 64'(ocnt), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        wait_res(1, r_acc, r_cnt, r_ovf);
        chk("bp_next_acc",   64'(r_acc), 64'd63);
        chk("bp_next_count", 64'(r_cnt), 64'd1);
        chk("bp_next_ovf",   64'(r_ovf), 64'd0);

        // Overflow on the 33-bit instance
        sel = 1'b1;
        beat(16'hFFFF, 16'hFFFF, 1'b0, 0);
        beat(16'hFFFF, 16'hFFFF, 1'b0, 0);
        beat(16'hFFFF, 16'hFFFF, 1'b1, 0);
        wait_res(2, r_acc, r_cnt, r_ovf);
        chk("ovf_acc",   64'(r_acc), 64'h0_FFFA_0003);
        chk("ovf_count", 64'(r_cnt), 64'd3);
        chk("ovf_flag",  64'(r_ovf), 64'd1);
        beat(16'd2, 16'd3, 1'b1, 0);
        wait_res(0, r_acc, r_cnt, r_ovf);
        chk("ovf_next_acc",  64'(r_acc), 64'd6);
        chk("ovf_next_flag", 64'(r_ovf), 64'd0);
        sel = 1'b0;

        // Mid-burst reset discards the partial sum
        for (int i = 1; i <= 4; i++) beat(16'(i), 16'(i), 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rdy",   64'(rdy),  64'd1);
        chk("mrst_acc",   64'(oacc), 64'd0);
        chk("mrst_count", 64'(ocnt), 64'd0);
        chk("mrst_valid", 64'(ovld), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(16'd3, 16'd5, 1'b1, 0);
        wait_res(0, r_acc, r_cnt, r_ovf);
        chk("mrst_res_acc",   64'(r_acc), 64'd15);
        chk("mrst_res_count", 64'(r_cnt), 64'd1);

        // Random bursts against a running-sum model
        for (int n = 0; n < 1000; n++) begin
            len   = $urandom_range(1, 8);
            m_acc = '0;
            m_ovf = 1'b0;
            for (int j = 0; j < len; j++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (j == len - 1) rl = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
                else              rl = 1'b0;
                m_sum = {1'b0, m_acc} + 41'(32'(ra) * 32'(rb));
                m_acc = m_sum[39:0];
                m_ovf = m_ovf | m_sum[40];
                beat(ra, rb, rl, $urandom_range(0, 2));
            end
            wait_res($urandom_range(0, 3), r_acc, r_cnt, r_ovf);
            chk("rand_acc",   64'(r_acc), 64'(m_acc));
            chk("rand_count", 64'(r_cnt), 64'(len));
            chk("rand_ovf",   64'(r_ovf), 64'(m_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
